coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Parametrised successor to the two-core memory controller: it arbitrates instruction fetches, data-block transfers and coherence traffic from `CPUS` caches onto one RAM port. It also runs snoop-based cache-to-cache forwarding with write-back, and invalidates on write upgrades. Arbitration is round-robin for both data and instruction traffic, and block length is set by `BLKWORDS`. The block sits between the per-core I/D caches and the RAM model, inside `memory_control`'s place in the system.

## Interface
- `CPUS`, 2: number of cores; legal range 2..8.
- `BLKWORDS`, 2: words per data block moved in one transaction; legal range 1..4.
- `CLK` in 1: system clock; all state updates on posedge.
- `nRST` in 1: reset, asynchronous and active-low.
- `iREN` in [CPUS]: instruction read request.
- `iaddr` in [CPUS] x 32: instruction word address.
- `iwait` out [CPUS]: instruction stall; low for exactly one cycle per word returned.
- `iload` out [CPUS] x 32: instruction data, valid while `iwait[k]`=0.
- `dREN` / `dWEN` in [CPUS]: block read / block write-back request.
- `daddr` in [CPUS] x 32: current word address; the cache advances it per word.
- `dstore` in [CPUS] x 32: write-back or forwarded data.
- `dwait` out [CPUS]: data stall; low for one cycle per word accepted or returned.
- `dload` out [CPUS] x 32: data to requester, valid while `dwait[k]`=0.
- `ccwrite` in [CPUS]: read-exclusive qualifier with `dREN`; alone, it is an upgrade (S->M) request.
- `cctrans` in [CPUS]: snooped cache holds the line Modified and will supply it.
- `ccwait` out [CPUS]: snoop hold; the cache services the snoop and does not issue requests.
- `ccinv` out [CPUS]: invalidate the line at `ccsnoopaddr[k]`.
- `ccsnoopaddr` out [CPUS] x 32: snoop address.
- `ramREN` / `ramWEN` out 1: RAM read / write.
- `ramaddr` / `ramstore` out 32: RAM address / write data.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: FREE/BUSY/ACCESS/ERROR; only ACCESS completes a word.

## Operation
- **Reset values.**
  - `iwait` and `dwait` all 1.
  - `iload`, `dload`, `ccsnoopaddr`, `ramaddr` and `ramstore` all 0.
  - `ccwait`, `ccinv`, `ramREN` and `ramWEN` all 0.
  - Data and instruction round-robin pointers = 0; word counter = 0; state IDLE.
- **Arbitration in IDLE.**
  - Data class (`dREN|dWEN|ccwrite`) strictly beats the instruction class (`iREN`).
  - Within a class, grant the first requester at or after that class's pointer, wrapping modulo `CPUS`.
  - On transaction completion, the class pointer becomes grant+1 (mod `CPUS`).
  - The granted index `g` is registered.
- **States:** IDLE, SNOOP, IFETCH, MEM2C, C2C, WB, INV, DONE.
- **IDLE ->**
  - INV if `ccwrite[g]` & ~`dREN[g]` & ~`dWEN[g]`.
  - WB if `dWEN[g]`.
  - SNOOP if `dREN[g]`.
  - IFETCH if the grant is instruction class.
- **SNOOP (1 cycle).** Drive `ccwait[k]`=1 and `ccsnoopaddr[k]`=`daddr[g]` for all k≠g.
  - Supplier `s` = lowest k≠g with `cctrans[k]`.
  - If a supplier exists -> C2C, else -> MEM2C.
  - Register `exclusive`=`ccwrite[g]`.
- **MEM2C.** `ramREN`=1, `ramaddr`=`daddr[g]`.
  - Each ACCESS cycle: `dload[g]`=`ramload`, `dwait[g]`=0, word counter +1.
- **C2C.** `ramWEN`=1, `ramaddr`=`daddr[s]`, `ramstore`=`dstore[s]`.
  - Each ACCESS cycle: `dload[g]`=`dstore[s]`, `dwait[g]`=0, `dwait[s]`=0, word counter +1.
- **WB.** `ramWEN`=1, `ramaddr`=`daddr[g]`, `ramstore`=`dstore[g]`.
  - Each ACCESS cycle: `dwait[g]`=0, word counter +1.
  - No snoop; `ccwait` stays 0 for others.
- **Snoop hold and exclusive reads.** During MEM2C and C2C, `ccwait[k≠g]` stays 1 and `ccsnoopaddr[k]`=`daddr[g]`. If `exclusive`, `ccinv[k≠g]`=1 in those states too.
- **Block end.** In MEM2C, C2C or WB, when the counter reaches `BLKWORDS`, clear it and go to DONE.
- **IFETCH.** `ramREN`=1, `ramaddr`=`iaddr[g]`.
  - On ACCESS: `iload[g]`=`ramload`, `iwait[g]`=0, -> DONE.
- **INV (1 cycle).** `ccwait`, `ccinv` = 1 and `ccsnoopaddr`=`daddr[g]` for all k≠g; `dwait[g]`=0 -> DONE.
- **DONE (1 cycle).** All outputs at their defaults; advance the pointer -> IDLE. This gives the requester one cycle to drop its request before re-arbitration.

## Timing
- SNOOP adds exactly 1 cycle before the first RAM access.
- A block takes SNOOP + `BLKWORDS` ACCESS cycles + DONE.
- BUSY or ERROR: hold all outputs and the state; do not retry or abort.
- Requests arriving outside IDLE are ignored until IDLE; no queuing.
- If `cctrans` rises on more than one core, the lowest index wins. Coherence allows only one.
- `dwait` and `iwait` are never low for two cores in the same cycle, except g and s in C2C.
- If `nRST` falls mid-transaction, all outputs go to reset values immediately; the RAM cycle is abandoned.
- A single requester re-requesting back-to-back is re-granted after DONE, with no lost cycles beyond DONE.

## Structure
- Add to `cpu_types_pkg`: `bus_state_t` enum, `word_t` reuse, `BLK_CNT_W` = `$clog2(BLKWORDS+1)`.
- Sub-module `rr_arbiter #(N)`: request vector in, pointer in, one-hot grant plus index out; purely combinational. Two instances are used (data, instruction).
- The top-level FSM, word counter and registers `g` / `s` / `exclusive` stay in `coherence_bus_ctrl`.

## Test plan
- CPUS=4, cores 0 and 2 `iREN` continuously, RAM latency 2 -> grants alternate 0,2,0,2; each `iwait` low 1 cycle per fetch.
- Core 1 `dREN` at `daddr`=0x100, no `cctrans`, BLKWORDS=2, RAM returns 0xA,0xB:
  - expect `ccwait[0,2,3]`=1 from SNOOP through the last word;
  - `dload[1]`=0xA, then 0xB.
- Core 0 `dREN`, core 3 `cctrans` with `dstore` 0x11,0x22:
  - expect `dload[0]`=0x11,0x22;
  - RAM writes 0x11,0x22 to `daddr[3]`;
  - `dwait[0]` and `dwait[3]` both low on each ACCESS.
- Core 2 `ccwrite` only at 0x40 -> one INV cycle with `ccinv[0,1,3]`=1, `ccsnoopaddr`=0x40; then DONE.
- Simultaneous `iREN[0]` and `dWEN[1]` -> WB for core 1 is granted first; IFETCH for core 0 follows after DONE.
- Assert `nRST`=0 mid-C2C -> next sample shows all outputs at their reset values; after release, a fresh `dREN` completes correctly.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-core coherence bus: RAM handshake states, the
// bus controller state encoding and the word-counter sizing.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    BUS_IDLE   = 3'd0,
    BUS_SNOOP  = 3'd1,
    BUS_IFETCH = 3'd2,
    BUS_MEM2C  = 3'd3,
    BUS_C2C    = 3'd4,
    BUS_WB     = 3'd5,
    BUS_INV    = 3'd6,
    BUS_DONE   = 3'd7
  } bus_state_t;

  // Counter is sized for the largest legal block so every instance shares one width.
  localparam int BLKWORDS_MAX = 4;
  localparam int BLK_CNT_W    = $clog2(BLKWORDS_MAX + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping modulo N. With no request the grant vector is all zero.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] rot_s;
  int           off_s;
  int           sum_s;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_s = N'({req_i, req_i} >> ptr_i);
    off_s = 0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? k : off_s;
    end
    sum_s = int'(ptr_i) + off_s;
    sum_s = (sum_s >= N) ? (sum_s - N) : sum_s;
    idx_o = IW'(sum_s);
    gnt_o = (|req_i) ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Multi-core memory bus controller: round-robin arbitration of instruction and
// data traffic onto one RAM port, with snoop-based cache-to-cache forwarding.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic       [CPUS-1:0]  iREN,
  input  word_t      [CPUS-1:0]  iaddr,
  output logic       [CPUS-1:0]  iwait,
  output word_t      [CPUS-1:0]  iload,
  input  logic       [CPUS-1:0]  dREN,
  input  logic       [CPUS-1:0]  dWEN,
  input  word_t      [CPUS-1:0]  daddr,
  input  word_t      [CPUS-1:0]  dstore,
  output logic       [CPUS-1:0]  dwait,
  output word_t      [CPUS-1:0]  dload,
  input  logic       [CPUS-1:0]  ccwrite,
  input  logic       [CPUS-1:0]  cctrans,
  output logic       [CPUS-1:0]  ccwait,
  output logic       [CPUS-1:0]  ccinv,
  output word_t      [CPUS-1:0]  ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output word_t                  ramaddr,
  output word_t                  ramstore,
  input  word_t                  ramload,
  input  ramstate_t              ramstate
);

  localparam int IW = $clog2(CPUS);

  bus_state_t           state_q, state_d;
  logic [IW-1:0]        g_q, g_d;
  logic [IW-1:0]        s_q, s_d;
  logic                 excl_q, excl_d;
  logic                 icls_q, icls_d;
  logic [BLK_CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]        dptr_q, dptr_d;
  logic [IW-1:0]        iptr_q, iptr_d;

  logic [CPUS-1:0]      d_req_s;
  logic [CPUS-1:0]      d_gnt_s;
  logic [CPUS-1:0]      i_gnt_s;
  logic [IW-1:0]        d_idx_s;
  logic [IW-1:0]        i_idx_s;
  logic [CPUS-1:0]      others_s;
  logic [CPUS-1:0]      cand_s;
  logic [IW-1:0]        sup_idx_s;
  logic                 sup_vld_s;
  word_t [CPUS-1:0]     snoop_addr_s;
  logic [BLK_CNT_W-1:0] cnt_inc_s;
  logic                 cnt_last_s;
  logic                 ram_done_s;
  logic [IW-1:0]        g_next_s;

  assign d_req_s = dREN | dWEN | ccwrite;

  rr_arbiter #(.N(CPUS)) u_darb (
    .req_i (d_req_s),
    .ptr_i (dptr_q),
    .gnt_o (d_gnt_s),
    .idx_o (d_idx_s)
  );

  rr_arbiter #(.N(CPUS)) u_iarb (
    .req_i (iREN),
    .ptr_i (iptr_q),
    .gnt_o (i_gnt_s),
    .idx_o (i_idx_s)
  );

  assign others_s   = ~(CPUS'(1) << g_q);
  assign cand_s     = cctrans & others_s;
  assign sup_vld_s  = |cand_s;
  assign cnt_inc_s  = cnt_q + BLK_CNT_W'(1);
  assign cnt_last_s = (cnt_inc_s == BLK_CNT_W'(BLKWORDS));
  assign ram_done_s = (ramstate == ACCESS);
  assign g_next_s   = (g_q == IW'(CPUS - 1)) ? '0 : (g_q + IW'(1));

  // Lowest-index snooped cache holding the line Modified, and per-core snoop addresses.
  always_comb begin
    sup_idx_s = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      sup_idx_s = cand_s[k] ? IW'(k) : sup_idx_s;
    end
    for (int k = 0; k < CPUS; k++) begin
      snoop_addr_s[k] = others_s[k] ? daddr[g_q] : '0;
    end
  end

  // State and transaction registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= BUS_IDLE;
      g_q     <= '0;
      s_q     <= '0;
      excl_q  <= 1'b0;
      icls_q  <= 1'b0;
      cnt_q   <= '0;
      dptr_q  <= '0;
      iptr_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      excl_q  <= excl_d;
      icls_q  <= icls_d;
      cnt_q   <= cnt_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
    end
  end

  // Next-state and bus outputs; BUSY/ERROR simply leave everything where it is.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    s_d         = s_q;
    excl_d      = excl_q;
    icls_d      = icls_q;
    cnt_d       = cnt_q;
    dptr_d      = dptr_q;
    iptr_d      = iptr_q;
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      BUS_IDLE: begin
        if (|d_gnt_s) begin
          g_d    = d_idx_s;
          icls_d = 1'b0;
          if (|(d_gnt_s & ccwrite & ~dREN & ~dWEN)) begin
            state_d = BUS_INV;
          end else if (|(d_gnt_s & dWEN)) begin
            state_d = BUS_WB;
          end else begin
            state_d = BUS_SNOOP;
          end
        end else if (|i_gnt_s) begin
          g_d     = i_idx_s;
          icls_d  = 1'b1;
          state_d = BUS_IFETCH;
        end else begin
          state_d = BUS_IDLE;
        end
      end

      BUS_SNOOP: begin
        ccwait      = others_s;
        ccsnoopaddr = snoop_addr_s;
        s_d         = sup_idx_s;
        excl_d      = ccwrite[g_q];
        if (sup_vld_s) begin
          state_d = BUS_C2C;
        end else begin
          state_d = BUS_MEM2C;
        end
      end

      BUS_MEM2C: begin
        ramREN      = 1'b1;
        ramaddr     = daddr[g_q];
        ccwait      = others_s;
        ccsnoopaddr = snoop_addr_s;
        ccinv       = excl_q ? others_s : '0;
        if (ram_done_s) begin
          dload[g_q] = ramload;
          dwait[g_q] = 1'b0;
          if (cnt_last_s) begin
            cnt_d   = '0;
            state_d = BUS_DONE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      BUS_C2C: begin
        // The supplier's data feeds the requester and is written back in the same beat.
        ramWEN      = 1'b1;
        ramaddr     = daddr[s_q];
        ramstore    = dstore[s_q];
        ccwait      = others_s;
        ccsnoopaddr = snoop_addr_s;
        ccinv       = excl_q ? others_s : '0;
        if (ram_done_s) begin
          dload[g_q] = dstore[s_q];
          dwait[g_q] = 1'b0;
          dwait[s_q] = 1'b0;
          if (cnt_last_s) begin
            cnt_d   = '0;
            state_d = BUS_DONE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      BUS_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g_q];
        ramstore = dstore[g_q];
        if (ram_done_s) begin
          dwait[g_q] = 1'b0;
          if (cnt_last_s) begin
            cnt_d   = '0;
            state_d = BUS_DONE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      BUS_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[g_q];
        if (ram_done_s) begin
          iload[g_q] = ramload;
          iwait[g_q] = 1'b0;
          state_d    = BUS_DONE;
        end else begin
          state_d = BUS_IFETCH;
        end
      end

      BUS_INV: begin
        ccwait      = others_s;
        ccinv       = others_s;
        ccsnoopaddr = snoop_addr_s;
        dwait[g_q]  = 1'b0;
        state_d     = BUS_DONE;
      end

      BUS_DONE: begin
        if (icls_q) begin
          iptr_d = g_next_s;
        end else begin
          dptr_d = g_next_s;
        end
        state_d = BUS_IDLE;
      end

      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with four cores, two-word blocks and a
// two-cycle RAM model.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  localparam int CPUS     = 4;
  localparam int BLKWORDS = 2;
  localparam int RAM_LAT  = 2;

  logic             CLK  = 1'b0;
  logic             nRST = 1'b0;
  logic [CPUS-1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
  word_t [CPUS-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]  iwait, dwait, ccwait, ccinv;
  word_t [CPUS-1:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [31:0]      mem [0:1023];
  int               lat_q;

  coherence_bus_ctrl #(.CPUS(CPUS), .BLKWORDS(BLKWORDS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: every access takes RAM_LAT cycles, the last one reported as ACCESS.
  assign ramstate = (ramREN || ramWEN) ? ((lat_q == RAM_LAT - 1) ? ACCESS : BUSY) : FREE;
  assign ramload  = mem[ramaddr[11:2]];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_q <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'hC0DE_0000;
      mem[128] <= 32'hC0DE_0002;
      mem[64]  <= 32'h0000_000A;
      mem[65]  <= 32'h0000_000B;
    end else if (ramREN || ramWEN) begin
      if (lat_q == RAM_LAT - 1) begin
        lat_q <= 0;
        if (ramWEN) mem[ramaddr[11:2]] <= ramstore;
      end else begin
        lat_q <= lat_q + 1;
      end
    end else begin
      lat_q <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    int nf, nw, cyc, last, exp_core;
    logic [3:0] exp_w;
    logic got;

    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0;

    repeat (3) @(posedge CLK);
    mid();
    check_eq("rst_iwait", iwait, 4'hF);
    check_eq("rst_dwait", dwait, 4'hF);
    check_eq("rst_cc", {ccwait, ccinv}, 8'h00);
    check_eq("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
    check_eq("rst_iload", iload, 128'h0);
    check_eq("rst_dload", dload, 128'h0);
    check_eq("rst_snoopaddr", ccsnoopaddr, 128'h0);
    step();
    nRST = 1'b1;

    // Instruction fetches from cores 0 and 2 alternate, one per 4 cycles.
    iaddr[0] = 32'h0;
    iaddr[2] = 32'h200;
    iREN = 4'b0101;
    nf = 0; cyc = 0; last = 0;
    while (nf < 4 && cyc < 60) begin
      mid();
      cyc++;
      if (iwait != 4'hF) begin
        exp_core = (nf % 2 == 0) ? 0 : 2;
        exp_w = 4'hF & ~(4'b0001 << exp_core);
        check_eq("t1_iwait", iwait, exp_w);
        check_eq("t1_iload", iload[exp_core], (exp_core == 0) ? 32'hC0DE_0000 : 32'hC0DE_0002);
        if (nf > 0) check_eq("t1_gap", cyc - last, 4);
        last = cyc;
        nf++;
      end
      step();
    end
    check_eq("t1_fetches", nf, 4);
    iREN = '0;
    step();

    // Core 1 block read from memory, no supplier.
    daddr[1] = 32'h100;
    dREN[1] = 1'b1;
    mid(); check_eq("t2_idle_ccwait", ccwait, 4'h0);
    step(); mid();
    check_eq("t2_snoop_ccwait", ccwait, 4'b1101);
    check_eq("t2_snoop_addr", ccsnoopaddr, {32'h100, 32'h100, 32'h0, 32'h100});
    check_eq("t2_snoop_ramren", ramREN, 1'b0);
    step(); mid();
    check_eq("t2_busy_ram", {ramREN, ramaddr}, {1'b1, 32'h100});
    check_eq("t2_busy_ccwait", ccwait, 4'b1101);
    check_eq("t2_busy_dwait", dwait, 4'hF);
    step(); mid();
    check_eq("t2_w0_dwait", dwait, 4'b1101);
    check_eq("t2_w0_dload", dload[1], 32'hA);
    check_eq("t2_w0_ccinv", ccinv, 4'h0);
    step(); daddr[1] = 32'h104; mid();
    check_eq("t2_w1_ramaddr", ramaddr, 32'h104);
    check_eq("t2_w1_ccwait", ccwait, 4'b1101);
    step(); mid();
    check_eq("t2_w1_dwait", dwait, 4'b1101);
    check_eq("t2_w1_dload", dload[1], 32'hB);
    check_eq("t2_w1_ccwait_last", ccwait, 4'b1101);
    step(); dREN[1] = 1'b0; mid();
    check_eq("t2_done", {ccwait, dwait, ramREN}, {4'h0, 4'hF, 1'b0});
    step();

    // Core 0 block read supplied by core 3 (Modified), written back to RAM.
    daddr[0] = 32'h300; daddr[3] = 32'h300; dstore[3] = 32'h11;
    cctrans[3] = 1'b1; dREN[0] = 1'b1;
    mid();
    step(); mid();
    check_eq("t3_snoop_ccwait", ccwait, 4'b1110);
    step(); mid();
    check_eq("t3_busy_ram", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h300, 32'h11});
    check_eq("t3_busy_dwait", dwait, 4'hF);
    step(); mid();
    check_eq("t3_w0_dwait", dwait, 4'b0110);
    check_eq("t3_w0_dload", dload[0], 32'h11);
    step(); daddr[0] = 32'h304; daddr[3] = 32'h304; dstore[3] = 32'h22; mid();
    check_eq("t3_w1_ramstore", ramstore, 32'h22);
    step(); mid();
    check_eq("t3_w1_dwait", dwait, 4'b0110);
    check_eq("t3_w1_dload", dload[0], 32'h22);
    step(); dREN[0] = 1'b0; cctrans[3] = 1'b0; mid();
    check_eq("t3_mem0", mem[192], 32'h11);
    check_eq("t3_mem1", mem[193], 32'h22);
    check_eq("t3_done_ramwen", ramWEN, 1'b0);
    step();

    // Core 2 upgrade: one INV cycle.
    daddr[2] = 32'h40; ccwrite[2] = 1'b1;
    mid();
    step(); mid();
    check_eq("t4_ccinv", ccinv, 4'b1011);
    check_eq("t4_ccwait", ccwait, 4'b1011);
    check_eq("t4_snoopaddr", ccsnoopaddr, {32'h40, 32'h0, 32'h40, 32'h40});
    check_eq("t4_dwait", dwait, 4'b1011);
    check_eq("t4_ram", {ramREN, ramWEN}, 2'b00);
    step(); ccwrite[2] = 1'b0; mid();
    check_eq("t4_done", {ccinv, dwait}, {4'h0, 4'hF});
    step();

    // Write-back from core 1 beats a simultaneous fetch from core 0.
    iaddr[0] = 32'h0; iREN[0] = 1'b1;
    daddr[1] = 32'h500; dstore[1] = 32'h55; dWEN[1] = 1'b1;
    mid();
    step(); mid();
    check_eq("t5_wb_ram", {ramREN, ramWEN, ramaddr, ramstore}, {2'b01, 32'h500, 32'h55});
    check_eq("t5_wb_ccwait", ccwait, 4'h0);
    check_eq("t5_wb_iwait", iwait, 4'hF);
    step(); mid();
    check_eq("t5_w0_dwait", dwait, 4'b1101);
    step(); daddr[1] = 32'h504; dstore[1] = 32'h66; mid();
    step(); mid();
    check_eq("t5_w1_dwait", dwait, 4'b1101);
    step(); dWEN[1] = 1'b0; mid();
    check_eq("t5_mem0", mem[320], 32'h55);
    check_eq("t5_mem1", mem[321], 32'h66);
    step(); mid();
    check_eq("t5_idle_iwait", iwait, 4'hF);
    step(); mid();
    check_eq("t5_if_ram", {ramREN, ramaddr}, {1'b1, 32'h0});
    step(); mid();
    check_eq("t5_if_iwait", iwait, 4'b1110);
    check_eq("t5_if_iload", iload[0], 32'hC0DE_0000);
    step(); iREN[0] = 1'b0;
    step();

    // Reset in the middle of a C2C transfer, then a fresh block read.
    daddr[1] = 32'h600; daddr[2] = 32'h600; dstore[2] = 32'h77;
    cctrans[2] = 1'b1; dREN[1] = 1'b1;
    mid();
    step(); mid();
    step(); mid();
    check_eq("t6_c2c_ram", {ramWEN, ramaddr}, {1'b1, 32'h600});
    #2 nRST = 1'b0;
    #1;
    check_eq("t6_rst_waits", {iwait, dwait}, 8'hFF);
    check_eq("t6_rst_cc", {ccwait, ccinv}, 8'h00);
    check_eq("t6_rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
    check_eq("t6_rst_loads", {iload, dload}, 256'h0);
    check_eq("t6_rst_snoopaddr", ccsnoopaddr, 128'h0);
    dREN = '0; cctrans = '0;
    step(); step();
    nRST = 1'b1;

    daddr[1] = 32'h100; dREN[1] = 1'b1;
    nw = 0; cyc = 0;
    while (nw < 2 && cyc < 20) begin
      mid();
      cyc++;
      got = 1'b0;
      if (dwait != 4'hF) begin
        check_eq("t6_dwait", dwait, 4'b1101);
        check_eq("t6_dload", dload[1], (nw == 0) ? 32'hA : 32'hB);
        nw++;
        got = 1'b1;
      end
      step();
      if (got) begin
        daddr[1] = daddr[1] + 32'd4;
        if (nw == 2) dREN[1] = 1'b0;
      end
    end
    check_eq("t6_words", nw, 2);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
